// File: rtl/packet_prefixer_pkg.sv
// Shared defaults and width helpers for the packet prefixer and its ring buffer.
package packet_prefixer_pkg;

  localparam int DEF_WORD_SIZE    = 8;
  localparam int DEF_INPUT_WORDS  = 4;
  localparam int DEF_OUTPUT_WORDS = 2;
  localparam int DEF_PREFIX_WORDS = 3;
  localparam int DEF_BUFFER_SIZE  = 32;

  // Bits needed to hold any value from 0 to max_val inclusive.
  function automatic int count_bits(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/word_ring_buffer.sv
// Circular word store with a variable-length multi-word write port and a
// fixed-width read port; words straddle the wrap point transparently.
module word_ring_buffer
  import packet_prefixer_pkg::*;
#(
  parameter int WORD_SIZE   = DEF_WORD_SIZE,
  parameter int MAX_WR      = DEF_INPUT_WORDS + DEF_PREFIX_WORDS,
  parameter int RD_WORDS    = DEF_OUTPUT_WORDS,
  parameter int BUFFER_SIZE = DEF_BUFFER_SIZE,
  localparam int PTR_W      = $clog2(BUFFER_SIZE),
  localparam int CNT_W      = PTR_W + 1,
  localparam int WRC_W      = count_bits(MAX_WR)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WRC_W-1:0]              wr_count,
  input  logic [WORD_SIZE*MAX_WR-1:0]   wr_words,
  input  logic                          rd_pop,
  output logic [WORD_SIZE*RD_WORDS-1:0] rd_data,
  output logic [CNT_W-1:0]              count
);

  logic [WORD_SIZE-1:0] mem [BUFFER_SIZE];
  logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]     count_reg, count_next;

  always_comb begin
    wr_ptr_next = wr_ptr_reg + PTR_W'(wr_count);
    rd_ptr_next = rd_pop ? rd_ptr_reg + PTR_W'(RD_WORDS) : rd_ptr_reg;
    count_next  = count_reg + CNT_W'(wr_count) - (rd_pop ? CNT_W'(RD_WORDS) : CNT_W'(0));
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM/LUTRAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_WR; i++) begin
      if (WRC_W'(i) < wr_count)
        mem[wr_ptr_reg + PTR_W'(i)] <= wr_words[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  for (genvar gi = 0; gi < RD_WORDS; gi++) begin : g_rd
    assign rd_data[gi*WORD_SIZE +: WORD_SIZE] = mem[rd_ptr_reg + PTR_W'(gi)];
  end

  assign count = count_reg;

endmodule

// File: rtl/packet_prefixer.sv
// Width-converting word FIFO that prepends a header ahead of every chunk
// flagged as a packet start.
module packet_prefixer
  import packet_prefixer_pkg::*;
#(
  parameter int WORD_SIZE    = DEF_WORD_SIZE,
  parameter int INPUT_WORDS  = DEF_INPUT_WORDS,
  parameter int OUTPUT_WORDS = DEF_OUTPUT_WORDS,
  parameter int PREFIX_WORDS = DEF_PREFIX_WORDS,
  parameter int BUFFER_SIZE  = DEF_BUFFER_SIZE
) (
  input  logic                              clk,
  input  logic                              rst_n,
  output logic                              in_full,
  input  logic                              in_shift,
  input  logic [WORD_SIZE*INPUT_WORDS-1:0]  in_data,
  input  logic [WORD_SIZE*PREFIX_WORDS-1:0] in_prefix,
  input  logic                              in_start,
  input  logic                              out_pop,
  output logic                              out_nempty,
  output logic [WORD_SIZE*OUTPUT_WORDS-1:0] out_data
);

  localparam int MAX_WR = PREFIX_WORDS + INPUT_WORDS;
  localparam int PTR_W  = $clog2(BUFFER_SIZE);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WRC_W  = count_bits(MAX_WR);

  logic [CNT_W-1:0]              count;
  logic [CNT_W-1:0]              free_words;
  logic                          accept;
  logic                          pop;
  logic [WRC_W-1:0]              wr_count;
  logic [WORD_SIZE*MAX_WR-1:0]   wr_words;

  // Full is judged against a worst-case prefixed chunk so it never depends
  // on in_start or a same-cycle pop.
  assign free_words = CNT_W'(BUFFER_SIZE) - count;
  assign in_full    = free_words < CNT_W'(MAX_WR);
  assign out_nempty = count >= CNT_W'(OUTPUT_WORDS);

  assign accept = in_shift && !in_full;
  assign pop    = out_pop && out_nempty;

  always_comb begin
    wr_words = '0;
    wr_count = '0;
    if (in_start) begin
      wr_words = {in_data, in_prefix};
      if (accept) wr_count = WRC_W'(MAX_WR);
    end else begin
      wr_words[WORD_SIZE*INPUT_WORDS-1:0] = in_data;
      if (accept) wr_count = WRC_W'(INPUT_WORDS);
    end
  end

  word_ring_buffer #(
    .WORD_SIZE  (WORD_SIZE),
    .MAX_WR     (MAX_WR),
    .RD_WORDS   (OUTPUT_WORDS),
    .BUFFER_SIZE(BUFFER_SIZE)
  ) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_count(wr_count),
    .wr_words(wr_words),
    .rd_pop  (pop),
    .rd_data (out_data),
    .count   (count)
  );

endmodule

// File: tb/tb_packet_prefixer.sv
// Directed bench for packet_prefixer: reset, prefix insertion, concurrent
// shift/pop, randomized streaming across wrap, full behaviour, mid-run reset.
module tb_packet_prefixer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_full;
  logic        in_shift;
  logic [31:0] in_data;
  logic [23:0] in_prefix;
  logic        in_start;
  logic        out_pop;
  logic        out_nempty;
  logic [15:0] out_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];

  packet_prefixer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_full   (in_full),
    .in_shift  (in_shift),
    .in_data   (in_data),
    .in_prefix (in_prefix),
    .in_start  (in_start),
    .out_pop   (out_pop),
    .out_nempty(out_nempty),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: append the bytes a shift is expected to store.
  task automatic model_push(input logic [31:0] data, input logic start);
    if (start) begin
      for (int k = 0; k < 3; k++) q.push_back(in_prefix[k*8 +: 8]);
    end
    for (int k = 0; k < 4; k++) q.push_back(data[k*8 +: 8]);
  endtask

  task automatic check_pop(input string tag);
    check(tag, {16'h0, out_data}, {16'h0, q[1], q[0]});
    void'(q.pop_front());
    void'(q.pop_front());
  endtask

  initial begin
    logic [19:0] start_pat;
    int sent;
    logic exp_full;

    rst_n = 1'b0; in_shift = 0; in_data = '0; in_prefix = 24'hccbbaa;
    in_start = 0; out_pop = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset state, pop while empty is ignored
    check("rst_nempty", out_nempty, 0);
    check("rst_full", in_full, 0);
    out_pop = 1; tick(); out_pop = 0;
    check("empty_pop_nempty", out_nempty, 0);

    // Prefixed chunk then three pops
    in_shift = 1; in_start = 1; in_data = 32'h10203040; tick();
    in_shift = 0; in_start = 0;
    check("pfx_nempty", out_nempty, 1);
    check("pfx_word0", out_data, 16'hbbaa);
    out_pop = 1; tick();
    check("pfx_word1", out_data, 16'h40cc);
    tick();
    check("pfx_word2", out_data, 16'h2030);
    tick();
    check("pfx_fourth_waits", out_nempty, 0);
    tick(); out_pop = 0;
    check("pfx_pop_ignored", out_nempty, 0);

    in_shift = 1; in_data = 32'h11223344; tick(); in_shift = 0;
    check("tail_join_nempty", out_nempty, 1);
    check("tail_join_data", out_data, 16'h4410);

    // Simultaneous non-start shift and pop: 5 + 4 - 2 = 7 words
    in_shift = 1; in_data = 32'h55667788; out_pop = 1; tick();
    in_shift = 0;
    check("sim_data0", out_data, 16'h2233);
    tick();
    check("sim_data1", out_data, 16'h8811);
    tick();
    check("sim_data2", out_data, 16'h6677);
    tick(); out_pop = 0;
    check("sim_left_one", out_nempty, 0);

    // Randomized stream of 20 chunks with the start pattern, across wrap
    q.delete();
    q.push_back(8'h55);
    start_pat = 20'b1001101001001;
    sent = 0;
    for (int cyc = 0; cyc < 800 && (sent < 20 || q.size() >= 2); cyc++) begin
      exp_full = (32 - q.size()) < 7;
      check("strm_full", in_full, exp_full);
      check("strm_nempty", out_nempty, q.size() >= 2);
      out_pop = ($urandom_range(0, 3) != 0);
      if (out_pop && q.size() >= 2) check_pop("strm_data");
      in_shift = (sent < 20) && ($urandom_range(0, 3) != 0);
      in_data  = 32'h10203040 | sent;
      in_start = (sent < 20) ? start_pat[sent] : 1'b0;
      if (in_shift && !exp_full) begin
        model_push(in_data, in_start);
        sent++;
      end
      tick();
    end
    in_shift = 0; in_start = 0; out_pop = 0;
    check("strm_all_sent", sent, 20);
    check("strm_drained", q.size() < 2, 1);

    // Fill without popping until full asserts
    for (int c = 0; c < 7; c++) begin
      check("fill_full_pre", in_full, (32 - q.size()) < 7);
      in_shift = 1; in_data = 32'ha0b0c0d0 + c;
      model_push(in_data, 1'b0);
      tick();
    end
    check("fill_full", in_full, 1);
    check("fill_count_ge26", q.size() >= 26, 1);
    in_data = 32'hffffffff; in_start = 1; tick(); tick();
    in_shift = 0; in_start = 0;
    check("fill_still_full", in_full, 1);
    out_pop = 1;
    while (q.size() >= 2) begin
      check_pop("fill_drain");
      tick();
    end
    out_pop = 0;
    check("fill_drain_empty", out_nempty, 0);
    check("fill_drain_notfull", in_full, 0);

    // Reset mid-stream discards buffered words
    in_shift = 1; in_data = 32'h01020304; tick(); in_shift = 0;
    check("mid_nempty_pre", out_nempty, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_nempty", out_nempty, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_full", in_full, 0);
    in_shift = 1; in_data = 32'hdeadbeef; tick(); in_shift = 0;
    check("post_rst_data0", out_data, 16'hbeef);
    out_pop = 1; tick();
    check("post_rst_data1", out_data, 16'hdead);
    tick(); out_pop = 0;
    check("post_rst_empty", out_nempty, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
